// File: rtl/launcher_pkg.sv
// Shared definitions for the program launcher.
//   state_t             : launcher FSM states
//   DEFAULT_TIMEOUT_CYC : RUN cycles before a program is declared hung
//   calc_pw()           : width of a program index (never less than 1 bit)
package launcher_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      RUN    = 3'd2,
      REPORT = 3'd3,
      GAP    = 3'd4
   } state_t;

   localparam logic [15:0] DEFAULT_TIMEOUT_CYC = 16'd4000;

   // A single program still needs a 1-bit select so the port never collapses.
   function automatic int calc_pw(input int n);
      int w;
      if (n <= 1) begin
         w = 1;
      end else begin
         w = $clog2(n);
      end
      return w;
   endfunction

endpackage

// File: rtl/run_counter.sv
// Clear/enable up-counter with a terminal-count compare.
// Ports:
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_clr          : clear to zero (wins over enable)
//   i_en           : count one step this cycle
//   i_last         : terminal value; o_tc is high while the count equals it
//   o_cnt          : current count
//   o_tc           : count == i_last
// The count holds at i_last instead of wrapping.
module run_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_last,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;
   logic         w_tc;

   assign w_tc  = (r_cnt == i_last);
   assign o_cnt = r_cnt;
   assign o_tc  = w_tc;

   // Count register: reset/clear to zero, otherwise step until terminal.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= {W{1'b0}};
      end else if (i_clr) begin
         r_cnt <= {W{1'b0}};
      end else if (i_en && !w_tc) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

endmodule

// File: rtl/prog_launcher.sv
// Host-side initiator for the processor Start/Ack run handshake. One Go runs
// NUM_PROGS programs back-to-back: Start is pulsed for START_LEN cycles, the
// RUN cycles until Ack are counted, and one result record is emitted per
// program (with a timeout for programs that never halt).
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_go            : sequence request, ignored while busy
//   i_ack           : processor halted flag (may be stale right after Start)
//   o_start         : start pulse to the processor
//   o_prog_sel      : program bank being run
//   o_busy          : sequence in progress
//   o_res_valid     : one-cycle strobe for o_res_idx/o_res_cycles/o_res_timeout
//   o_res_idx       : program index of the record
//   o_res_cycles    : RUN cycles until Ack, or TIMEOUT_CYC on timeout
//   o_res_timeout   : record ended by timeout
//   o_all_done      : last record emitted, until the next accepted Go or reset
module prog_launcher
   import launcher_pkg::*;
#(
   parameter  int            NUM_PROGS   = 3,
   parameter  int            START_LEN   = 2,
   parameter  int            ACK_MASK    = 1,
   parameter  int            CW          = 16,
   parameter  logic [CW-1:0] TIMEOUT_CYC = CW'(DEFAULT_TIMEOUT_CYC),
   localparam int            PW          = calc_pw(NUM_PROGS)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_go,
   input  logic          i_ack,
   output logic          o_start,
   output logic [PW-1:0] o_prog_sel,
   output logic          o_busy,
   output logic          o_res_valid,
   output logic [PW-1:0] o_res_idx,
   output logic [CW-1:0] o_res_cycles,
   output logic          o_res_timeout,
   output logic          o_all_done
);

   localparam logic [CW-1:0] LAUNCH_LAST = CW'(START_LEN - 1);
   localparam logic [CW-1:0] RUN_LAST    = TIMEOUT_CYC - CW'(1);
   localparam logic [CW-1:0] MASK_LIM    = CW'(ACK_MASK);
   localparam logic [PW-1:0] LAST_PROG   = PW'(NUM_PROGS - 1);

   state_t          r_state;
   state_t          w_next_state;
   logic            w_ack_hit;
   logic            w_launch_tc;
   logic [CW-1:0]   w_unused_launch_cnt;
   logic            w_run_tc;
   logic [CW-1:0]   w_run_cnt;
   logic [CW-1:0]   w_run_cur;

   logic            r_start;
   logic [PW-1:0]   r_prog_sel;
   logic            r_busy;
   logic            r_res_valid;
   logic [PW-1:0]   r_res_idx;
   logic [CW-1:0]   r_res_cycles;
   logic            r_res_timeout;
   logic            r_all_done;

   // Counts cycles spent in LAUNCH; terminal after START_LEN cycles.
   run_counter #(.W(CW)) u_launch_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (r_state != LAUNCH),
      .i_en    (r_state == LAUNCH),
      .i_last  (LAUNCH_LAST),
      .o_cnt   (w_unused_launch_cnt),
      .o_tc    (w_launch_tc)
   );

   // Counts completed RUN cycles; terminal on the TIMEOUT_CYC-th RUN cycle.
   run_counter #(.W(CW)) u_run_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (r_state != RUN),
      .i_en    (r_state == RUN),
      .i_last  (RUN_LAST),
      .o_cnt   (w_run_cnt),
      .o_tc    (w_run_tc)
   );

   // The counter holds completed cycles, so the current RUN cycle is one more.
   assign w_run_cur = w_run_cnt + CW'(1);

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic; Ack only counts in RUN past the stale-halt window.
   always_comb begin
      w_next_state = r_state;
      w_ack_hit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_go) begin
               w_next_state = LAUNCH;
            end else begin
               w_next_state = IDLE;
            end
         end
         LAUNCH: begin
            if (w_launch_tc) begin
               w_next_state = RUN;
            end else begin
               w_next_state = LAUNCH;
            end
         end
         RUN: begin
            w_ack_hit = i_ack && (w_run_cur > MASK_LIM);
            if (w_ack_hit || w_run_tc) begin
               w_next_state = REPORT;
            end else begin
               w_next_state = RUN;
            end
         end
         REPORT: begin
            if (r_prog_sel == LAST_PROG) begin
               w_next_state = IDLE;
            end else begin
               w_next_state = GAP;
            end
         end
         GAP: begin
            w_next_state = LAUNCH;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Registered outputs, decoded from the state being entered. Ack wins over
   // a simultaneous timeout because w_ack_hit is tested first.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_start       <= 1'b0;
         r_prog_sel    <= {PW{1'b0}};
         r_busy        <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_idx     <= {PW{1'b0}};
         r_res_cycles  <= {CW{1'b0}};
         r_res_timeout <= 1'b0;
         r_all_done    <= 1'b0;
      end else begin
         r_start     <= (w_next_state == LAUNCH);
         r_busy      <= (w_next_state != IDLE);
         r_res_valid <= (w_next_state == REPORT);
         if ((r_state == RUN) && (w_next_state == REPORT)) begin
            r_res_idx     <= r_prog_sel;
            r_res_timeout <= ~w_ack_hit;
            r_res_cycles  <= w_ack_hit ? w_run_cur : TIMEOUT_CYC;
         end
         if ((r_state == IDLE) && i_go) begin
            r_prog_sel <= {PW{1'b0}};
            r_all_done <= 1'b0;
         end else if (r_state == GAP) begin
            r_prog_sel <= r_prog_sel + PW'(1);
         end else if ((r_state == REPORT) && (w_next_state == IDLE)) begin
            r_all_done <= 1'b1;
         end
      end
   end

   assign o_start       = r_start;
   assign o_prog_sel    = r_prog_sel;
   assign o_busy        = r_busy;
   assign o_res_valid   = r_res_valid;
   assign o_res_idx     = r_res_idx;
   assign o_res_cycles  = r_res_cycles;
   assign o_res_timeout = r_res_timeout;
   assign o_all_done    = r_all_done;

endmodule

// File: tb/tb_prog_launcher.sv
// Self-checking bench for prog_launcher (NUM_PROGS=3, START_LEN=2,
// ACK_MASK=1, TIMEOUT_CYC=50). Each Go sequence is described by per-program
// Ack latencies; a schedule builder turns that into per-cycle input vectors
// and expected outputs using phase-length arithmetic.
module tb_prog_launcher;

   localparam int NP = 3;
   localparam int SL = 2;
   localparam int AM = 1;
   localparam int CW = 16;
   localparam int TO = 50;
   localparam int PW = 2;
   localparam int N  = 270;

   logic          clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_go = 1'b0;
   logic          i_ack = 1'b0;
   logic          o_start;
   logic [PW-1:0] o_prog_sel;
   logic          o_busy;
   logic          o_res_valid;
   logic [PW-1:0] o_res_idx;
   logic [CW-1:0] o_res_cycles;
   logic          o_res_timeout;
   logic          o_all_done;

   prog_launcher #(
      .NUM_PROGS(NP), .START_LEN(SL), .ACK_MASK(AM), .CW(CW), .TIMEOUT_CYC(16'd50)
   ) dut (
      .i_clk(clk), .i_reset(i_reset), .i_go(i_go), .i_ack(i_ack),
      .o_start(o_start), .o_prog_sel(o_prog_sel), .o_busy(o_busy),
      .o_res_valid(o_res_valid), .o_res_idx(o_res_idx), .o_res_cycles(o_res_cycles),
      .o_res_timeout(o_res_timeout), .o_all_done(o_all_done)
   );

   always #5 clk = ~clk;

   // stimulus per cycle
   bit go_a[N];
   bit rst_a[N];
   bit ack_a[N];
   // directly scheduled expectations
   bit e_start[N];
   bit e_busy[N];
   bit e_valid[N];
   // events that change held outputs
   bit ev_res[N];
   int ev_idx[N];
   int ev_cyc[N];
   int ev_to[N];
   bit ev_sel[N];
   int ev_selv[N];
   bit ev_done_set[N];
   bit ev_done_clr[N];
   // held expectations after forward fill
   logic [PW-1:0] e_idx[N];
   logic [CW-1:0] e_cyc[N];
   bit            e_to[N];
   logic [PW-1:0] e_sel[N];
   bit            e_done[N];

   typedef struct { int idx; int cyc; int to; } rec_t;
   rec_t mq[$];
   rec_t dq[$];

   int lit_idx[12] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
   int lit_cyc[12] = '{7, 20, 3, 5, 50, 4, 50, 10, 6, 2, 3, 4};
   int lit_to[12]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Schedule one Go sequence. lat=0 means the program never halts; stale
   // bit p holds Ack high through program p's launch and first RUN cycle.
   // Nothing after cycle lim is scheduled (a reset lands there).
   task automatic build_seq(input int g, input int l0, input int l1, input int l2,
                            input bit [2:0] stale, input int lim);
      int lat, r, to, b, rep;
      rec_t rc;
      b = g;
      go_a[g] = 1'b1;
      if (g + 1 <= lim) begin
         ev_done_clr[g+1] = 1'b1;
         ev_sel[g+1] = 1'b1;
         ev_selv[g+1] = 0;
      end
      for (int p = 0; p < NP; p++) begin
         lat = (p == 0) ? l0 : ((p == 1) ? l1 : l2);
         if (lat > 0 && lat <= TO) begin r = lat; to = 0; end
         else begin r = TO; to = 1; end
         rep = b + SL + r + 1;
         if (p > 0 && b + 1 <= lim) begin
            ev_sel[b+1] = 1'b1;
            ev_selv[b+1] = p;
         end
         for (int c = b + 1; c <= rep; c++) begin
            if (c <= lim) begin
               e_busy[c] = 1'b1;
               if (c <= b + SL) e_start[c] = 1'b1;
               if (stale[p] && c <= b + SL + 1) ack_a[c] = 1'b1;
               if (lat > 0 && c >= b + SL + lat) ack_a[c] = 1'b1;
            end
         end
         if (rep <= lim) begin
            e_valid[rep] = 1'b1;
            ev_res[rep] = 1'b1;
            ev_idx[rep] = p;
            ev_cyc[rep] = r;
            ev_to[rep] = to;
            rc.idx = p; rc.cyc = r; rc.to = to;
            mq.push_back(rc);
         end
         if (p == NP - 1) begin
            if (rep + 1 <= lim) ev_done_set[rep+1] = 1'b1;
         end else begin
            if (rep + 1 <= lim) e_busy[rep+1] = 1'b1;
            b = rep + 1;
         end
      end
   endtask

   // Carry held outputs forward cycle by cycle; a reset zeroes them.
   task automatic fill_model();
      int hi, hc, ht, hs, hd;
      hi = 0; hc = 0; ht = 0; hs = 0; hd = 0;
      for (int c = 1; c < N; c++) begin
         if (rst_a[c-1]) begin
            hi = 0; hc = 0; ht = 0; hs = 0; hd = 0;
            e_start[c] = 1'b0; e_busy[c] = 1'b0; e_valid[c] = 1'b0;
         end else begin
            if (ev_res[c]) begin hi = ev_idx[c]; hc = ev_cyc[c]; ht = ev_to[c]; end
            if (ev_sel[c]) hs = ev_selv[c];
            if (ev_done_clr[c]) hd = 0;
            if (ev_done_set[c]) hd = 1;
         end
         e_idx[c]  = PW'(hi);
         e_cyc[c]  = CW'(hc);
         e_to[c]   = (ht != 0);
         e_sel[c]  = PW'(hs);
         e_done[c] = (hd != 0);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en && cyc >= 1 && cyc < N) begin
         checks++;
         if (o_start !== e_start[cyc] || o_busy !== e_busy[cyc] ||
             o_res_valid !== e_valid[cyc] || o_res_idx !== e_idx[cyc] ||
             o_res_cycles !== e_cyc[cyc] || o_res_timeout !== e_to[cyc] ||
             o_prog_sel !== e_sel[cyc] || o_all_done !== e_done[cyc]) begin
            errors++;
            $display("FAIL cycle %0d got start=%b busy=%b valid=%b idx=%0d cyc=%0d to=%b sel=%0d done=%b expected start=%b busy=%b valid=%b idx=%0d cyc=%0d to=%b sel=%0d done=%b",
                     cyc, o_start, o_busy, o_res_valid, o_res_idx, o_res_cycles,
                     o_res_timeout, o_prog_sel, o_all_done,
                     e_start[cyc], e_busy[cyc], e_valid[cyc], e_idx[cyc], e_cyc[cyc],
                     e_to[cyc], e_sel[cyc], e_done[cyc]);
         end
         if (o_res_valid === 1'b1) begin
            rec_t rc;
            rc.idx = int'(o_res_idx);
            rc.cyc = int'(o_res_cycles);
            rc.to  = int'(o_res_timeout);
            dq.push_back(rc);
         end
      end
   end

   initial begin
      rst_a[0] = 1'b1;
      rst_a[1] = 1'b1;
      // 7, 20, 3 from a freshly reset launcher
      build_seq(3, 7, 20, 3, 3'b000, N - 1);
      // stale Ack on program 0, hang on program 1; Go arrives while AllDone
      build_seq(50, 5, 0, 4, 3'b001, N - 1);
      // Ack exactly on the timeout cycle, stale Ack on program 1
      build_seq(130, 50, 10, 6, 3'b010, N - 1);
      go_a[150] = 1'b1;   // mid-RUN, must be ignored
      go_a[183] = 1'b1;   // during REPORT, must be ignored
      // reset on RUN cycle 10 of program 0, after an ignored mid-RUN Go
      build_seq(215, 30, 5, 5, 3'b000, 227);
      go_a[222] = 1'b1;
      rst_a[227] = 1'b1;
      // restart after reset
      build_seq(235, 2, 3, 4, 3'b000, N - 1);
      fill_model();

      // pin the model with hand-computed values
      chk("model_rec_count", mq.size(), 12);
      for (int i = 0; i < mq.size() && i < 12; i++) begin
         chk($sformatf("model_rec%0d_idx", i), mq[i].idx, lit_idx[i]);
         chk($sformatf("model_rec%0d_cyc", i), mq[i].cyc, lit_cyc[i]);
         chk($sformatf("model_rec%0d_to", i), mq[i].to, lit_to[i]);
      end
      chk("model_start_c4", int'(e_start[4]), 1);
      chk("model_start_c6", int'(e_start[6]), 0);
      chk("model_valid_c13", int'(e_valid[13]), 1);
      chk("model_done_c44", int'(e_done[44]), 0);
      chk("model_done_c45", int'(e_done[45]), 1);
      chk("model_busy_c228", int'(e_busy[228]), 0);

      cyc = 0;
      i_go = go_a[0]; i_reset = rst_a[0]; i_ack = ack_a[0];
      cmp_en = 1'b1;
      for (int c = 1; c < N; c++) begin
         @(posedge clk);
         #1;
         cyc = c;
         i_go = go_a[c]; i_reset = rst_a[c]; i_ack = ack_a[c];
      end
      @(posedge clk);
      #1;
      cmp_en = 1'b0;

      // records seen on the DUT against literal expectations
      chk("dut_rec_count", dq.size(), 12);
      for (int i = 0; i < dq.size() && i < 12; i++) begin
         chk($sformatf("dut_rec%0d_idx", i), dq[i].idx, lit_idx[i]);
         chk($sformatf("dut_rec%0d_cyc", i), dq[i].cyc, lit_cyc[i]);
         chk($sformatf("dut_rec%0d_to", i), dq[i].to, lit_to[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_launcher.md
Name: prog_launcher

Overview:
Host-side initiator for the processor's Start/Ack run handshake; it drives the processor's Start input and watches its Ack (halt) output.
On one Go pulse it runs NUM_PROGS programs back-to-back. For each program it pulses Start, waits for Ack and measures the cycles executed.
It emits one result record per program, with a timeout for programs that never halt.
It sits beside TopLevel in the test harness or host wrapper and selects the program bank through ProgSel.

Parameters:
NUM_PROGS, 3, number of programs run per Go.
START_LEN, 2, cycles Start is held high per launch (minimum 1).
ACK_MASK, 1, cycles after Start falls during which Ack is ignored (stale halt from the previous program).
CW, 16, width of the cycle counter and ResCycles.
TIMEOUT_CYC, 16'd4000, RUN cycles before the program is declared hung (must be at most 2^CW-1).

Ports:
Clk  in  1  clock, posedge only.
Reset  in  1  synchronous, active-high reset.
Go  in  1  one-cycle request to start a sequence; ignored while Busy.
Ack  in  1  done flag from the processor; may be high at any time, including during Start.
Start  out  1  start pulse to the processor.
ProgSel  out  PW=$clog2(NUM_PROGS) (min 1)  index of the program being run.
Busy  out  1  high from the cycle after an accepted Go until AllDone.
ResValid  out  1  one-cycle strobe qualifying the Res* outputs.
ResIdx  out  PW  program index of the record.
ResCycles  out  CW  RUN cycles counted until Ack; TIMEOUT_CYC on timeout.
ResTimeout  out  1  record ended by timeout.
AllDone  out  1  high after the last record until the next accepted Go or Reset.

Behaviour:
- Reset (synchronous, wins over everything): state IDLE, Start=0, ProgSel=0, Busy=0, ResValid=0, ResIdx=0, ResCycles=0, ResTimeout=0, AllDone=0, counters cleared.
- Reset mid-run: immediate return to IDLE on the next edge; no record is emitted.
- States: IDLE, LAUNCH, RUN, REPORT, GAP.
- IDLE: Go=1 -> LAUNCH; ProgSel=0; Busy=1; AllDone=0.
- LAUNCH: Start=1 for exactly START_LEN cycles, then -> RUN. Ack is ignored throughout LAUNCH.
- RUN: Start=0. A cycle counter is cleared on entry and increments by 1 every RUN cycle.
  - The first ACK_MASK RUN cycles ignore Ack.
  - Ack=1 (unmasked) -> REPORT with ResCycles = the count including the current cycle (first RUN cycle counts as 1), ResTimeout=0.
  - Count reaching TIMEOUT_CYC without an unmasked Ack -> REPORT with ResCycles=TIMEOUT_CYC, ResTimeout=1.
  - Ack and timeout in the same cycle: Ack wins (ResTimeout=0).
- REPORT: ResValid=1 for one cycle; ResIdx=ProgSel.
  - Res* hold their values after the strobe until the next REPORT.
  - If ProgSel==NUM_PROGS-1 -> IDLE with AllDone=1 and Busy=0 on the next cycle.
  - Otherwise -> GAP.
- GAP: one cycle with Start=0; ProgSel increments; -> LAUNCH.
- Go while Busy: ignored.
- Go while AllDone=1: accepted like IDLE Go and clears AllDone.
- Start is never high outside LAUNCH. Start and ResValid are never high in the same cycle.
- Latency: Go at edge t gives Start high on cycles t+1..t+START_LEN.
- Total cycles per program = START_LEN + RUN cycles + 1 (REPORT) + 1 (GAP, omitted for the last program).
- Counter is CW bits wide and never wraps; TIMEOUT_CYC bounds it.

Decomposition:
- Package launcher_pkg holds:
  - the state typedef enum logic [2:0] {IDLE, LAUNCH, RUN, REPORT, GAP};
  - PW derivation helper;
  - default TIMEOUT_CYC constant.
- One sub-module, run_counter: clear/enable counter with a terminal-count compare, used for both the START_LEN phase count and the RUN cycle count (two instances).
- FSM and result registers stay in prog_launcher.

Test Plan:
- NUM_PROGS=1, START_LEN=2: Go; model asserts Ack on RUN cycle 10 -> Start high exactly 2 cycles; ResValid once with ResIdx=0, ResCycles=10, ResTimeout=0; AllDone=1 next cycle.
- Stale Ack: model holds Ack=1 throughout LAUNCH and the first RUN cycle, then real Ack at RUN cycle 5 -> ResCycles=5, not 1.
- NUM_PROGS=3: Ack latencies 7, 20, 3 -> records (0,7), (1,20), (2,3) in order; ProgSel steps 0->1->2; Start low for exactly 1 GAP cycle between launches.
- Hang with TIMEOUT_CYC=50: Ack never rises on program 1 -> record (1,50,ResTimeout=1); program 2 still launches and completes normally.
- Boundary: Ack first seen on RUN cycle 50 with TIMEOUT_CYC=50 -> ResCycles=50, ResTimeout=0.
- Control: Go pulsed mid-RUN is ignored. Reset asserted mid-RUN -> all outputs 0 next cycle and no ResValid. A later Go after AllDone restarts at ProgSel=0 with AllDone cleared.
